aes_req_ctrl: RTL and testbench
===============================

Name: aes_req_ctrl

Overview:
Request/response sequencer that sits directly upstream and downstream of the AES top (cipher/inv-cipher core). It accepts one encrypt or decrypt job through a valid/ready handshake and holds key, text and mode stable at the core. It pulses the core's load strobe, waits for done, and captures the result into a response register. The consumer drains that register with a second valid/ready handshake. A watchdog converts a missing done into an error response.

Parameters:
TIMEOUT_CYC, 64, max cycles waited in BUSY for core_done before flagging an error; legal range 2..1023.
CNT_W, 16, width of the completed-job counter.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  job offered
req_ready  out  1  controller can accept a job
req_mode  in  1  0 = encrypt, 1 = decrypt
req_key  in  128  cipher key
req_text  in  128  plaintext or ciphertext
core_ld  out  1  one-cycle load strobe to AES top
core_mode  out  1  mode to AES top
core_key  out  128  key to AES top
core_text  out  128  text_in to AES top
core_done  in  1  AES top done
core_text_out  in  128  AES top result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_text  out  128  result (0 on error)
rsp_mode  out  1  mode of the job that produced this response
rsp_err  out  1  1 = job timed out
busy  out  1  state != IDLE
job_cnt  out  CNT_W  jobs completed without error; wraps to 0 after all-ones

Behaviour:
- Reset, synchronous, active-high: state=IDLE. All outputs and internal registers (key, text, mode, watchdog, job_cnt) clear to 0. Exception: req_ready is 1 in the first cycle after reset, because IDLE drives it high.
- Reset mid-operation: the next edge forces IDLE. core_ld is not asserted in the reset cycle. Any in-flight core_done is ignored afterwards.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_mode/key/text into core_* registers and go to LOAD.
  - With no req_valid, stay in IDLE.
- LOAD:
  - core_ld=1 for exactly this one cycle.
  - Go to BUSY and clear the watchdog to 0.
  - Accept-to-core_ld latency is 1 cycle.
- BUSY:
  - Watchdog increments every cycle.
  - If core_done=1: rsp_text<=core_text_out, rsp_mode<=core_mode, rsp_err<=0, job_cnt increments, go to RESP.
  - Else if watchdog==TIMEOUT_CYC-1: rsp_text<=0, rsp_mode<=core_mode, rsp_err<=1, job_cnt unchanged, go to RESP.
  - If core_done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1.
  - rsp_text, rsp_mode and rsp_err are held stable until rsp_ready=1.
  - On the handshake go to IDLE, and rsp_valid drops the next cycle.
- core_key/core_text/core_mode stay stable from LOAD until the next accept. They are never changed while the core is busy.
- core_done in IDLE, LOAD or RESP is ignored. It produces no state change and no capture.
- req_ready=0 in LOAD, BUSY and RESP. There is no same-cycle RESP->accept, so minimum job spacing is latency + 3 cycles.
- Watchdog width is ceil(log2(TIMEOUT_CYC)) bits and saturates; it cannot wrap.
- job_cnt is CNT_W bits and wraps modulo 2^CNT_W.

Test Plan:
- Encrypt: mode=0, key=000102030405060708090a0b0c0d0e0f, text=00112233445566778899aabbccddeeff -> core_ld high exactly 1 cycle, 1 cycle after accept. Then rsp_valid with rsp_text=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0, rsp_mode=0, job_cnt=1.
- Decrypt: mode=1, same key, text=69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_text=00112233445566778899aabbccddeeff, rsp_mode=1, rsp_err=0.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_* stable, req_ready=0, and a req_valid presented during this time is not accepted. Raise rsp_ready -> req_ready=1 one cycle after the handshake.
- Timeout: core model never asserts done, TIMEOUT_CYC=8 -> rsp_valid on the 8th BUSY cycle boundary with rsp_err=1, rsp_text=0, job_cnt unchanged. A core_done injected on the final watchdog cycle instead -> rsp_err=0.
- Reset mid-BUSY: assert rst for 1 cycle 3 cycles after core_ld -> next cycle state IDLE, all outputs 0 except req_ready=1. A late core_done is ignored and no rsp_valid appears.
- Counter wrap with CNT_W=4: run 17 good jobs -> job_cnt reads 0xF after 15, then 0x0, then 0x1. A stray core_done in IDLE leaves the count unchanged.

Source files
------------

// File: rtl/aes_req_ctrl.sv
// aes_req_ctrl: request/response sequencer around the AES top.
//   Accepts one encrypt/decrypt job over req_valid/req_ready and holds
//   key/text/mode stable at the core. It pulses core_ld for one cycle and
//   waits for core_done. The result (or a timeout error) is captured into a
//   response register, which is drained over rsp_valid/rsp_ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           job handshake
//   req_mode/req_key/req_text     job payload (mode: 0 enc, 1 dec)
//   core_ld/core_mode/core_key/core_text   drive to AES top
//   core_done/core_text_out       completion and result from AES top
//   rsp_valid/rsp_ready           response handshake
//   rsp_text/rsp_mode/rsp_err     response payload (text 0 on error)
//   busy                          controller not idle
//   job_cnt                       jobs completed without error (wraps)
module aes_req_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mode,
    input  logic [127:0]     req_key,
    input  logic [127:0]     req_text,
    output logic             core_ld,
    output logic             core_mode,
    output logic [127:0]     core_key,
    output logic [127:0]     core_text,
    input  logic             core_done,
    input  logic [127:0]     core_text_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [127:0]     rsp_text,
    output logic             rsp_mode,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] job_cnt
);

    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wdog;

    logic accept;
    logic done_hit;
    logic tmo_hit;

    // Event decodes; done takes priority over the watchdog.
    assign accept   = (state == S_IDLE) && req_valid;
    assign done_hit = (state == S_BUSY) && core_done;
    assign tmo_hit  = (state == S_BUSY) && !core_done && (wdog == WD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid)           state_nxt = S_LOAD;
            S_LOAD:                          state_nxt = S_BUSY;
            S_BUSY: if (done_hit || tmo_hit) state_nxt = S_RESP;
            S_RESP: if (rsp_ready)           state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // Handshake/strobe outputs decoded straight from the state register.
    always_comb begin
        req_ready = 1'b0;
        core_ld   = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD:  core_ld   = 1'b1;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Job payload held at the core; only reloaded on a new accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_mode <= 1'b0;
            core_key  <= '0;
            core_text <= '0;
        end else if (accept) begin
            core_mode <= req_mode;
            core_key  <= req_key;
            core_text <= req_text;
        end
    end

    // Watchdog: cleared on load, counts in BUSY, saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (state == S_LOAD) begin
            wdog <= '0;
        end else if ((state == S_BUSY) && (wdog != WD_MAX)) begin
            wdog <= wdog + WD_W'(1);
        end
    end

    // Response capture and good-job counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_text <= '0;
            rsp_mode <= 1'b0;
            rsp_err  <= 1'b0;
            job_cnt  <= '0;
        end else if (done_hit) begin
            rsp_text <= core_text_out;
            rsp_mode <= core_mode;
            rsp_err  <= 1'b0;
            job_cnt  <= job_cnt + CNT_W'(1);
        end else if (tmo_hit) begin
            rsp_text <= '0;
            rsp_mode <= core_mode;
            rsp_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_req_ctrl.sv
// tb_aes_req_ctrl: directed bench for aes_req_ctrl with a stub AES core that
// maps the FIPS-197 AES-128 vector both ways and returns ~text otherwise.
module tb_aes_req_ctrl;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALT = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_mode;
    logic [127:0] req_key;
    logic [127:0] req_text;
    logic         core_ld;
    logic         core_mode;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] core_text_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_text;
    logic         rsp_mode;
    logic         rsp_err;
    logic         busy;
    logic [3:0]   job_cnt;

    int n_chk;
    int n_fail;

    aes_req_ctrl #(
        .TIMEOUT_CYC(8),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_key      (req_key),
        .req_text     (req_text),
        .core_ld      (core_ld),
        .core_mode    (core_mode),
        .core_key     (core_key),
        .core_text    (core_text),
        .core_done    (core_done),
        .core_text_out(core_text_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_text     (rsp_text),
        .rsp_mode     (rsp_mode),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .job_cnt      (job_cnt)
    );

    function automatic logic [127:0] aes_stub(input logic m, input logic [127:0] t);
        if (!m && t == PT) return CT;
        if (m && t == CT)  return PT;
        return ~t;
    endfunction

    assign core_text_out = aes_stub(core_mode, core_text);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one job for a single cycle; returns with the DUT in LOAD.
    task automatic issue(input logic m, input logic [127:0] k, input logic [127:0] t);
        req_mode  = m;
        req_key   = k;
        req_text  = t;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_key   = '0;
        req_text  = '0;
        core_done = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        // Reset state
        chk("rst_req_ready", req_ready, 1);
        chk("rst_core_ld",   core_ld, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_job_cnt",   job_cnt, 0);
        chk("rst_core_key",  core_key, 0);
        chk("rst_rsp_text",  rsp_text, 0);
        rst = 1'b0;
        step();

        // Encrypt
        issue(1'b0, KEY, PT);
        chk("enc_core_ld",   core_ld, 1);
        chk("enc_req_ready", req_ready, 0);
        chk("enc_core_key",  core_key, KEY);
        chk("enc_core_text", core_text, PT);
        chk("enc_core_mode", core_mode, 0);
        step();
        chk("enc_core_ld_1cyc", core_ld, 0);
        chk("enc_busy", busy, 1);
        step();
        step();
        chk("enc_no_rsp_yet", rsp_valid, 0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("enc_rsp_valid", rsp_valid, 1);
        chk("enc_rsp_text",  rsp_text, CT);
        chk("enc_rsp_err",   rsp_err, 0);
        chk("enc_rsp_mode",  rsp_mode, 0);
        chk("enc_job_cnt",   job_cnt, 1);
        drain();
        chk("enc_rsp_drop",  rsp_valid, 0);
        chk("enc_req_ready_back", req_ready, 1);

        // Decrypt
        issue(1'b1, KEY, CT);
        chk("dec_core_mode", core_mode, 1);
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("dec_rsp_valid", rsp_valid, 1);
        chk("dec_rsp_text",  rsp_text, PT);
        chk("dec_rsp_mode",  rsp_mode, 1);
        chk("dec_rsp_err",   rsp_err, 0);
        chk("dec_job_cnt",   job_cnt, 2);
        drain();

        // Backpressure with a competing request offered
        issue(1'b0, KEY, PT);
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        req_mode  = 1'b1;
        req_text  = ALT;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_text",  rsp_text, CT);
            chk("bp_req_ready", req_ready, 0);
        end
        chk("bp_core_text_held", core_text, PT);
        chk("bp_core_mode_held", core_mode, 0);
        req_valid = 1'b0;
        drain();
        chk("bp_req_ready_after", req_ready, 1);
        chk("bp_rsp_drop", rsp_valid, 0);
        chk("bp_job_cnt", job_cnt, 3);

        // Timeout: no done ever
        issue(1'b1, KEY, ALT);
        step();
        for (int i = 0; i < 7; i++) step();
        chk("tmo_not_early", rsp_valid, 0);
        step();
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err",   rsp_err, 1);
        chk("tmo_rsp_text",  rsp_text, 0);
        chk("tmo_rsp_mode",  rsp_mode, 1);
        chk("tmo_job_cnt",   job_cnt, 3);
        drain();

        // Done on the final watchdog cycle wins over timeout
        issue(1'b0, KEY, ALT);
        step();
        for (int i = 0; i < 7; i++) step();
        chk("tmo2_not_early", rsp_valid, 0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("tmo2_rsp_valid", rsp_valid, 1);
        chk("tmo2_rsp_err",   rsp_err, 0);
        chk("tmo2_rsp_text",  rsp_text, ~ALT);
        chk("tmo2_job_cnt",   job_cnt, 4);
        drain();

        // Reset mid-BUSY
        issue(1'b1, KEY, CT);
        step();
        step();
        step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_req_ready", req_ready, 1);
        chk("mid_busy_clr",  busy, 0);
        chk("mid_core_ld",   core_ld, 0);
        chk("mid_core_mode", core_mode, 0);
        chk("mid_core_key",  core_key, 0);
        chk("mid_core_text", core_text, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_text",  rsp_text, 0);
        chk("mid_rsp_err",   rsp_err, 0);
        chk("mid_job_cnt",   job_cnt, 0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        chk("mid_late_done_rsp", rsp_valid, 0);
        chk("mid_late_done_cnt", job_cnt, 0);
        chk("mid_late_done_busy", busy, 0);

        // Counter wrap (4-bit)
        for (int j = 1; j <= 17; j++) begin
            issue(1'b0, KEY, PT);
            step();
            core_done = 1'b1;
            step();
            core_done = 1'b0;
            chk("wrap_rsp_valid", rsp_valid, 1);
            chk("wrap_job_cnt", job_cnt, 128'(j % 16));
            drain();
        end
        chk("wrap_final", job_cnt, 4'h1);

        // Stray done in IDLE
        core_done = 1'b1;
        step();
        step();
        core_done = 1'b0;
        chk("stray_job_cnt",   job_cnt, 4'h1);
        chk("stray_rsp_valid", rsp_valid, 0);
        chk("stray_busy",      busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
